// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell stepped LSB-first,
// operands taken and the result returned over valid/ready handshakes.
module adder (
    input  logic carry_i,
    input  logic a_i,
    input  logic b_i,
    output logic carry_o,
    output logic sum_o
);

    assign sum_o   = a_i ^ b_i ^ carry_i;
    assign carry_o = (a_i & b_i) | (carry_i & (a_i ^ b_i));

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             busy_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             cell_sum;
    logic             cell_cy;
    logic             accept;
    logic             last;

    assign accept = valid_i && ready_o;
    assign last   = (cnt == LAST);

    adder u_cell (
        .carry_i (cy),
        .a_i     (a_q[cnt]),
        .b_i     (b_q[cnt]),
        .carry_o (cell_cy),
        .sum_o   (cell_sum)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (accept) next = RUN;
            RUN:     if (last) next = DONE;
            DONE:    if (ready_i) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // ready_o drops with rst_i itself so a reset edge never doubles as an accept
    always_comb begin
        ready_o = (state == IDLE) && !rst_i;
        valid_o = (state == DONE);
        busy_o  = (state != IDLE);
        sum_o   = res;
        carry_o = cy;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q <= '0;
            b_q <= '0;
            res <= '0;
            cnt <= '0;
            cy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q <= a_i;
                        b_q <= b_i;
                        cy  <= carry_i;
                        res <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    res[cnt] <= cell_sum;
                    cy       <= cell_cy;
                    cnt      <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: latency, sums,
// backpressure, operand isolation, mid-run reset, back-to-back rate.
module tb_serial_adder_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       carry_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] sum_o;
    logic       carry_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .carry_i (carry_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sum_o   (sum_o),
        .carry_o (carry_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after accept.
    task automatic start(input logic [7:0] a, input logic [7:0] b,
                         input logic c);
        a_i     = a;
        b_i     = b;
        carry_i = c;
        valid_i = 1'b1;
        chk("rdy_idle", ready_o, 1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        chk("busy_run", busy_o, 1);
    endtask

    task automatic wait_done(input logic [7:0] es, input logic ec);
        int k;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) break;
        end
        chk("latency", k, 8);
        chk("sum", sum_o, es);
        chk("cout", carry_o, ec);
        chk("rdy_done", ready_o, 0);
    endtask

    task automatic finish_op(input logic [7:0] es);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("vld_low", valid_o, 0);
        chk("rdy_back", ready_o, 1);
        chk("busy_low", busy_o, 0);
        chk("sum_hold", sum_o, es);
    endtask

    logic [7:0] ta [4];
    logic [7:0] tb [4];
    logic       tci[4];
    logic [7:0] ts [4];
    logic       tc [4];

    initial begin
        int stale;
        int idx;
        int r;
        int last_t;
        logic rdy;

        ta[0] = 8'hA5; tb[0] = 8'h5A; tci[0] = 0; ts[0] = 8'hFF; tc[0] = 0;
        ta[1] = 8'h80; tb[1] = 8'h80; tci[1] = 1; ts[1] = 8'h01; tc[1] = 1;
        ta[2] = 8'h7F; tb[2] = 8'h01; tci[2] = 1; ts[2] = 8'h81; tc[2] = 0;
        ta[3] = 8'hC3; tb[3] = 8'h4E; tci[3] = 0; ts[3] = 8'h11; tc[3] = 1;

        rst_i   = 1'b1;
        valid_i = 1'b1;
        ready_i = 1'b1;
        a_i     = 8'h12;
        b_i     = 8'h34;
        carry_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_rdy", ready_o, 0);
        chk("rst_vld", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_sum", sum_o, 0);
        chk("rst_cout", carry_o, 0);
        valid_i = 1'b0;
        rst_i   = 1'b0;
        #1;
        chk("rel_rdy", ready_o, 1);

        @(posedge clk_i);
        #1;
        start(8'h3C, 8'h0F, 0);
        wait_done(8'h4B, 0);
        finish_op(8'h4B);

        start(8'hFF, 8'h01, 0);
        wait_done(8'h00, 1);
        finish_op(8'h00);
        start(8'hFF, 8'hFF, 1);
        wait_done(8'hFF, 1);
        finish_op(8'hFF);
        start(8'h00, 8'h00, 1);
        wait_done(8'h01, 0);
        finish_op(8'h01);

        // backpressure: hold result, ignore stray requests
        ready_i = 1'b0;
        start(8'h3C, 8'h0F, 0);
        wait_done(8'h4B, 0);
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            a_i     = 8'hF0 + 8'(i);
            b_i     = 8'h77;
            carry_i = 1'b1;
            @(posedge clk_i);
            #1;
            chk("bp_vld", valid_o, 1);
            chk("bp_sum", sum_o, 8'h4B);
            chk("bp_cout", carry_o, 0);
            chk("bp_rdy", ready_o, 0);
        end
        valid_i = 1'b0;
        finish_op(8'h4B);

        // operand change during RUN
        start(8'h10, 8'h20, 0);
        a_i     = 8'hAA;
        b_i     = 8'h55;
        carry_i = 1'b1;
        wait_done(8'h30, 0);
        finish_op(8'h30);

        // reset at cnt=3
        start(8'h3C, 8'h0F, 0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_rdy", ready_o, 0);
        @(posedge clk_i);
        #1;
        chk("mid_vld", valid_o, 0);
        chk("mid_busy", busy_o, 0);
        chk("mid_sum", sum_o, 0);
        chk("mid_cout", carry_o, 0);
        rst_i = 1'b0;
        #1;
        chk("mid_rel_rdy", ready_o, 1);
        stale = 0;
        repeat (10) begin
            @(posedge clk_i);
            #1;
            if (valid_o) stale++;
        end
        chk("no_stale", stale, 0);
        start(8'h01, 8'h01, 0);
        wait_done(8'h02, 0);
        finish_op(8'h02);

        // back-to-back with handshakes held high
        idx     = 0;
        r       = 0;
        last_t  = 0;
        a_i     = ta[0];
        b_i     = tb[0];
        carry_i = tci[0];
        valid_i = 1'b1;
        ready_i = 1'b1;
        for (int c = 1; c <= 80 && r < 4; c++) begin
            rdy = ready_o;
            @(posedge clk_i);
            #1;
            if (rdy && valid_i) begin
                idx++;
                if (idx < 4) begin
                    a_i     = ta[idx];
                    b_i     = tb[idx];
                    carry_i = tci[idx];
                end else begin
                    valid_i = 1'b0;
                end
            end
            if (valid_o) begin
                chk("b2b_sum", sum_o, ts[r]);
                chk("b2b_cout", carry_o, tc[r]);
                if (r > 0) chk("b2b_gap", c - last_t, 10);
                last_t = c;
                r++;
            end
        end
        chk("b2b_count", r, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
